// File: rtl/dds_voice_scheduler.sv
// Time-multiplexed phase accumulator for VOICES DDS voices, stepped once per sample tick.
// Optional hard-sync ports (sync_req/sync_voice) are built when HARD_SYNC_EN is defined.
module dds_voice_scheduler #(
    parameter int VOICES = 4,
    parameter int N      = 23,
    parameter int M      = 14,
    parameter int TUNE   = 16,
    parameter int DIV    = 19
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef HARD_SYNC_EN
    input  logic                       sync_req,
    input  logic [$clog2(VOICES)-1:0]  sync_voice,
`endif
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [$clog2(VOICES)-1:0]  cfg_voice,
    input  logic [TUNE-1:0]            cfg_tuning,
    input  logic                       cfg_enable,
    output logic [M-1:0]               phase_out,
    output logic [$clog2(VOICES)-1:0]  phase_voice,
    output logic                       phase_valid,
    output logic                       frame_done,
    output logic                       busy,
    output logic                       overrun
);
    localparam int VW = $clog2(VOICES);
    localparam int CW = $clog2(DIV);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [VW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N-1:0]      phase_q  [VOICES];
    logic [TUNE-1:0]   tuning_q [VOICES];
    logic              enable_q [VOICES];
    logic [M-1:0]      phase_out_q;
    logic [VW-1:0]     phase_voice_q;
    logic              phase_valid_q;
    logic              frame_done_q;
    logic              overrun_q;

    logic              tick_s;
    logic              last_s;
    logic              cfg_we_s;
    logic [N-1:0]      step_phase_s;

    assign tick_s    = (cnt_q == CW'(DIV - 1));
    assign last_s    = (idx_q == VW'(VOICES - 1));
    assign cfg_ready = (state_q == IDLE) && !tick_s;
    assign cfg_we_s  = cfg_valid && cfg_ready;
    assign busy      = (state_q == RUN);

    // The single shared adder: disabled voices pass their phase through unchanged.
    always_comb begin
        step_phase_s = phase_q[idx_q];
        if (enable_q[idx_q]) begin
            step_phase_s = phase_q[idx_q] + N'(tuning_q[idx_q]);
        end else begin
            step_phase_s = phase_q[idx_q];
        end
    end

    // Next-state logic for the tick divider and the IDLE/RUN sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = tick_s ? '0 : cnt_q + CW'(1);
        case (state_q)
            IDLE: begin
                if (tick_s) begin
                    state_d = RUN;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                idx_d = idx_q + VW'(1);
                if (last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Control registers and the registered phase stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            phase_out_q   <= '0;
            phase_voice_q <= '0;
            phase_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            phase_valid_q <= (state_q == RUN);
            frame_done_q  <= (state_q == RUN) && last_s;
            if (state_q == RUN) begin
                phase_out_q   <= step_phase_s[N-1 -: M];
                phase_voice_q <= idx_q;
            end
            // A tick landing mid-frame is only recorded, never queued.
            if (tick_s && (state_q == RUN)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Per-voice storage: accumulation in RUN, host config and hard sync in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VOICES; v++) begin
                phase_q[v]  <= '0;
                tuning_q[v] <= '0;
                enable_q[v] <= 1'b0;
            end
        end else begin
            if (state_q == RUN) begin
                phase_q[idx_q] <= step_phase_s;
            end
`ifdef HARD_SYNC_EN
            if (sync_req && (state_q == IDLE)) begin
                phase_q[sync_voice] <= '0;
            end
`endif
            if (cfg_we_s) begin
                tuning_q[cfg_voice] <= cfg_tuning;
                enable_q[cfg_voice] <= cfg_enable;
            end
        end
    end

    assign phase_out   = phase_out_q;
    assign phase_voice = phase_voice_q;
    assign phase_valid = phase_valid_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_dds_voice_scheduler.sv
// Directed self-checking bench for dds_voice_scheduler with a small per-voice phase model.
// Exercises the hard-sync ports as well when HARD_SYNC_EN is defined.
module tb_dds_voice_scheduler;
    localparam int VOICES = 4;
    localparam int N      = 23;
    localparam int M      = 14;
    localparam int TUNE   = 16;
    localparam int DIV    = 19;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_voice;
    logic [TUNE-1:0]   cfg_tuning;
    logic              cfg_enable;
    logic [M-1:0]      phase_out;
    logic [1:0]        phase_voice;
    logic              phase_valid;
    logic              frame_done;
    logic              busy;
    logic              overrun;
`ifdef HARD_SYNC_EN
    logic              sync_req;
    logic [1:0]        sync_voice;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0]    mph  [VOICES];
    logic [TUNE-1:0] mtun [VOICES];
    logic            men  [VOICES];

    dds_voice_scheduler #(
        .VOICES(VOICES), .N(N), .M(M), .TUNE(TUNE), .DIV(DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef HARD_SYNC_EN
        .sync_req    (sync_req),
        .sync_voice  (sync_voice),
`endif
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_voice   (cfg_voice),
        .cfg_tuning  (cfg_tuning),
        .cfg_enable  (cfg_enable),
        .phase_out   (phase_out),
        .phase_voice (phase_voice),
        .phase_valid (phase_valid),
        .frame_done  (frame_done),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        for (int v = 0; v < VOICES; v++) begin
            mph[v]  = '0;
            mtun[v] = '0;
            men[v]  = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int v = 0; v < VOICES; v++) begin
            if (men[v]) mph[v] = mph[v] + N'(mtun[v]);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_phase_out"},   32'(phase_out),   32'd0);
        check_eq({tag, "_phase_voice"}, 32'(phase_voice), 32'd0);
        check_eq({tag, "_phase_valid"}, 32'(phase_valid), 32'd0);
        check_eq({tag, "_frame_done"},  32'(frame_done),  32'd0);
        check_eq({tag, "_busy"},        32'(busy),        32'd0);
        check_eq({tag, "_overrun"},     32'(overrun),     32'd0);
    endtask

    // Waits for the next frame's beats and checks all VOICES of them against the model.
    task automatic check_frame(input string tag);
        int n;
        n = 0;
        model_step();
        while (!phase_valid && n < 2 * DIV + 4) begin
            @(negedge clk);
            n++;
        end
        if (!phase_valid) begin
            check_eq({tag, "_beat_timeout"}, 32'(phase_valid), 32'd1);
            return;
        end
        for (int v = 0; v < VOICES; v++) begin
            check_eq({tag, "_valid"}, 32'(phase_valid), 32'd1);
            check_eq({tag, "_voice"}, 32'(phase_voice), 32'(v));
            check_eq({tag, "_phase"}, 32'(phase_out),   32'(mph[v][N-1 -: M]));
            check_eq({tag, "_done"},  32'(frame_done),  32'(v == VOICES - 1));
            @(negedge clk);
        end
        check_eq({tag, "_valid_after"}, 32'(phase_valid), 32'd0);
    endtask

    task automatic cfg_write(input logic [1:0] v, input logic [TUNE-1:0] tun, input logic en);
        logic acc;
        acc = 1'b0;
        @(negedge clk);
        cfg_valid  = 1'b1;
        cfg_voice  = v;
        cfg_tuning = tun;
        cfg_enable = en;
        for (int i = 0; i < 4 * DIV; i++) begin
            if (cfg_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("cfg_write_accept", 32'(acc), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        mtun[v] = tun;
        men[v]  = en;
    endtask

    initial begin
        int n;
        int run_cycles;
        logic acc;
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_voice  = 2'd0;
        cfg_tuning = '0;
        cfg_enable = 1'b0;
`ifdef HARD_SYNC_EN
        sync_req   = 1'b0;
        sync_voice = 2'd0;
`endif
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check_eq("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;

        // All voices disabled: three frames of zero phases.
        for (int f = 0; f < 3; f++) check_frame("idle_zero");
        check_eq("idle_overrun", 32'(overrun), 32'd0);

        // Voice 1 stepping by 0x4000 -> phase_out 0x20, 0x40, 0x60.
        cfg_write(2'd1, 16'h4000, 1'b1);
        for (int f = 0; f < 3; f++) check_frame("v1_step");
        check_eq("v1_third_value", 32'(mph[1][N-1 -: M]), 32'h60);

        // Voice 0 at 0xFFFF wraps 2^23 on its 129th step.
        cfg_write(2'd0, 16'hFFFF, 1'b1);
        for (int f = 0; f < 130; f++) check_frame("v0_wrap");
        check_eq("wrap_overrun", 32'(overrun), 32'd0);

        // Request held across a tick: refused through RUN, accepted back in IDLE.
        n = 0;
        while (!(!busy && !cfg_ready) && n < 3 * DIV) begin
            @(negedge clk);
            n++;
        end
        check_eq("hold_tick_seen", 32'(!busy && !cfg_ready), 32'd1);
        cfg_valid  = 1'b1;
        cfg_voice  = 2'd2;
        cfg_tuning = 16'h1200;
        cfg_enable = 1'b1;
        run_cycles = 0;
        acc = 1'b0;
        for (int i = 0; i < 3 * DIV; i++) begin
            if (cfg_ready) begin
                acc = 1'b1;
                break;
            end
            if (busy) run_cycles++;
            @(negedge clk);
        end
        check_eq("hold_accept", 32'(acc), 32'd1);
        check_eq("hold_run_cycles", 32'(run_cycles), 32'(VOICES));
        check_eq("hold_accept_idle", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        model_step();
        mtun[2] = 16'h1200;
        men[2]  = 1'b1;
        check_frame("hold_effect");

        // Reset on the second beat of a frame.
        n = 0;
        while (!phase_valid && n < 3 * DIV) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_first_beat", 32'(phase_valid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("mid_rst");
        rst = 1'b0;
        model_clear();
        n = 0;
        while (!busy && n < 3 * DIV) begin
            check_eq("post_rst_no_done", 32'(frame_done), 32'd0);
            @(negedge clk);
            n++;
        end
        check_eq("post_rst_tick_delay", 32'(n), 32'(DIV));
        check_frame("post_rst_zero");

`ifdef HARD_SYNC_EN
        // Hard sync of voice 2 restarts its phase from zero.
        cfg_write(2'd2, 16'h1200, 1'b1);
        check_frame("sync_pre");
        check_frame("sync_pre");
        check_eq("sync_pre_value", 32'(mph[2][N-1 -: M]), 32'd18);
        sync_req   = 1'b1;
        sync_voice = 2'd2;
        @(posedge clk);
        @(negedge clk);
        sync_req = 1'b0;
        mph[2] = '0;
        check_frame("sync_post");
`endif

        check_eq("final_overrun", 32'(overrun), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_voice_scheduler.md
Name: dds_voice_scheduler

Overview:
Time-multiplexes one phase-accumulator adder across VOICES independent DDS voices. Holds the tuning word, enable and N-bit phase register for each voice. Generates the sample-rate tick from the system clock. On each tick it steps every voice once, in order, and streams the truncated phases to the downstream waveform lookup. Sits between the host/config logic and the phase-to-amplitude stage.

Parameters:
VOICES, 4, number of voices; power of two, at least 2.
N, 23, phase register width per voice.
M, 14, truncated phase output width, M <= N.
TUNE, 16, tuning word width, TUNE <= N.
DIV, 19, system clocks per sample tick; must be >= VOICES+1.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous active-high reset.
cfg_valid  input  1  config write request.
cfg_ready  output  1  config write accepted when valid&ready.
cfg_voice  input  log2(VOICES)  voice index to configure.
cfg_tuning  input  TUNE  tuning word for that voice.
cfg_enable  input  1  voice enable; 0 freezes the phase.
phase_out  output  M  phase[N-1:N-M] of the voice just stepped.
phase_voice  output  log2(VOICES)  voice index for phase_out.
phase_valid  output  1  phase_out and phase_voice are valid this cycle.
frame_done  output  1  one-cycle pulse after the last voice of a frame.
busy  output  1  high while in RUN.
overrun  output  1  sticky; set when a tick arrives during RUN.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - All phase, tuning and enable storage cleared to 0.
  - Tick counter cleared to 0; state = IDLE.
  - Outputs after reset: phase_out=0, phase_voice=0, phase_valid=0, frame_done=0, busy=0, overrun=0.
  - rst overrides every other input, including mid-frame: the frame is abandoned with no frame_done.
- Tick counter:
  - Counts 0..DIV-1 and wraps to 0.
  - tick is asserted internally for the one cycle when the count equals DIV-1.
  - The counter runs freely in every state.
- FSM states: IDLE and RUN.
  - IDLE -> RUN on tick; voice index idx set to 0.
  - In RUN, each cycle processes voice idx:
    - If enabled: phase[idx] <= phase[idx] + zero-extended tuning[idx], modulo 2^N (wrap silently).
    - If disabled: phase[idx] is held.
    - idx increments each cycle.
  - RUN -> IDLE after processing idx = VOICES-1.
  - busy = (state == RUN).
- Output timing:
  - phase_out carries the updated phase truncated to the top M bits, registered.
  - phase_valid, phase_out and phase_voice are valid 1 cycle after the processing cycle.
  - Disabled voices still emit a phase_valid beat with the held phase.
  - Exactly VOICES consecutive phase_valid beats per frame, voice order 0..VOICES-1.
  - frame_done pulses together with the final beat (phase_voice = VOICES-1).
- Config handshake:
  - cfg_ready = (state == IDLE) && !tick.
  - On valid&ready, tuning and enable are written for cfg_voice at that posedge. The new values are used from the next frame.
  - While ready = 0 the host holds its request.
  - A write and a tick never coincide; a tick takes priority by dropping cfg_ready.
- Overrun:
  - A tick while in RUN sets overrun and is otherwise ignored; no extra frame is queued.
  - overrun is cleared only by rst.
  - This cannot occur when DIV >= VOICES+1.

Optional Feature:
Macro HARD_SYNC_EN.
- Defined:
  - Adds input sync_req (1) and sync_voice (log2(VOICES)).
  - sync_req is accepted only in IDLE and zeroes phase[sync_voice] at that posedge; the 0 is visible in the next frame's step.
  - If sync_req and a valid cfg write target the same voice in the same cycle, both apply.
  - sync_req in RUN is ignored.
- Undefined: the ports do not exist and phases are modified only by accumulation and rst.

Test Plan:
- Reset then idle 3*DIV cycles, all voices disabled -> 3 frames, each with beats voice 0..3, phase_out=0, frame_done on voice 3, overrun=0.
- Write voice1 tuning=0x4000, enabled; other voices disabled -> voice1 phase_out steps by 0x4000>>9 = 0x20 per frame (0x20, 0x40, ...); voices 0, 2, 3 stay 0.
- Voice0 tuning=0xFFFF with phase preloaded near 2^23 by repeated frames -> phase wraps modulo 2^23, phase_out drops to a small value, no flag raised.
- Hold cfg_valid asserted continuously across a tick -> cfg_ready=0 throughout RUN; the write lands in IDLE and takes effect the following frame.
- rst asserted on the 2nd beat of a frame -> next cycle all outputs 0; no frame_done; the next tick arrives DIV cycles after rst is released.
- HARD_SYNC_EN defined: sync_req for voice2 in IDLE -> voice2's next beat shows phase_out = tuning2>>9, i.e. the phase restarted from 0.
